// File: rtl/max7000_config_loader_if.sv
// -----------------------------------------------------------------------------
// max7000_config_loader_if
//
// Byte-stream handshake carrying the configuration image into the loader.
//   data_in    : image byte
//   data_valid : data_in holds a byte (driven by the source)
//   data_ready : loader accepts a byte this cycle (driven by the loader)
// A byte moves on any rising clock edge where data_valid and data_ready are
// both high.
//   master modport : byte source (testbench / upstream programmer)
//   slave modport  : max7000_config_loader
// -----------------------------------------------------------------------------
interface max7000_config_loader_if;
  logic [7:0] data_in;
  logic       data_valid;
  logic       data_ready;

  modport master (
    output data_in,
    output data_valid,
    input  data_ready
  );

  modport slave (
    input  data_in,
    input  data_valid,
    output data_ready
  );
endinterface : max7000_config_loader_if

// File: rtl/max7000_config_loader.sv
// -----------------------------------------------------------------------------
// max7000_config_loader
//
// Configuration controller for the MAX7000 device model. Receives the image as
// BYTE_COUNT data bytes followed by a 16-bit additive checksum (high byte
// first), assembles the data in a shadow register and only commits it to the
// bitstream output once the checksum matches. A failed or aborted load leaves
// the previously committed configuration untouched.
//
// Ports:
//   clk          : single clock, all state changes on its rising edge
//   reset_n      : asynchronous active-low reset
//   start        : pulse that begins a load (honoured in IDLE/DONE/ERROR)
//   abort        : return to IDLE from any state (wins over start)
//   stream       : byte handshake (data_in / data_valid / data_ready)
//   bitstream    : committed configuration vector
//   busy         : high in LOAD, CKSUM_HI, CKSUM_LO and CHECK
//   config_done  : high in DONE
//   config_error : high in ERROR
//   byte_count   : data bytes accepted in the current load
// -----------------------------------------------------------------------------
module max7000_config_loader #(
  parameter int BIT_COUNT  = 15033,
  // Derived from BIT_COUNT; not meant to be overridden.
  parameter int BYTE_COUNT = (BIT_COUNT + 7) / 8
) (
  input  logic                         clk,
  input  logic                         reset_n,
  input  logic                         start,
  input  logic                         abort,
  max7000_config_loader_if.slave       stream,
  output logic [BIT_COUNT-1:0]         bitstream,
  output logic                         busy,
  output logic                         config_done,
  output logic                         config_error,
  output logic [10:0]                  byte_count
);

  localparam int          SHADOW_W = BYTE_COUNT * 8;
  // byte_count value held while the final data byte is being accepted.
  localparam logic [10:0] LAST_IDX = 11'(BYTE_COUNT - 1);

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    LOAD     = 3'd1,
    CKSUM_HI = 3'd2,
    CKSUM_LO = 3'd3,
    CHECK    = 3'd4,
    DONE     = 3'd5,
    ERROR    = 3'd6
  } state_t;

  // Running checksum: mod-2^16 sum of zero-extended bytes, wraps silently.
  function automatic logic [15:0] add_byte(input logic [15:0] sum,
                                           input logic [7:0]  b);
    return sum + {8'h00, b};
  endfunction

  state_t                state_q,     state_d;
  logic [SHADOW_W-1:0]   shadow_q,    shadow_d;
  logic [15:0]           sum_q,       sum_d;
  logic [15:0]           expect_q,    expect_d;
  logic [10:0]           count_q,     count_d;
  logic [BIT_COUNT-1:0]  bitstream_q, bitstream_d;
  logic                  ready_q,     ready_d;
  logic                  busy_q,      busy_d;
  logic                  done_q,      done_d;
  logic                  error_q,     error_d;
  logic                  xfer_s;

  // ready_q always mirrors the current state, so this is the true handshake.
  assign xfer_s = stream.data_valid & ready_q;

  // Next-state, datapath and registered-output decode.
  always_comb begin
    state_d     = state_q;
    shadow_d    = shadow_q;
    sum_d       = sum_q;
    expect_d    = expect_q;
    count_d     = count_q;
    bitstream_d = bitstream_q;

    if (abort) begin
      // Abort drops the load in progress but never touches bitstream.
      state_d  = IDLE;
      shadow_d = {SHADOW_W{1'b0}};
      sum_d    = 16'h0000;
      expect_d = 16'h0000;
      count_d  = 11'd0;
    end else begin
      case (state_q)
        IDLE, DONE, ERROR: begin
          if (start) begin
            state_d  = LOAD;
            shadow_d = {SHADOW_W{1'b0}};
            sum_d    = 16'h0000;
            expect_d = 16'h0000;
            count_d  = 11'd0;
          end else begin
            state_d = state_q;
          end
        end

        LOAD: begin
          if (xfer_s) begin
            // First byte ends up in the MSBs once all bytes are shifted in.
            shadow_d = {shadow_q[SHADOW_W-9:0], stream.data_in};
            sum_d    = add_byte(sum_q, stream.data_in);
            count_d  = count_q + 11'd1;
            if (count_q == LAST_IDX) begin
              state_d = CKSUM_HI;
            end else begin
              state_d = LOAD;
            end
          end else begin
            state_d = LOAD;
          end
        end

        CKSUM_HI: begin
          if (xfer_s) begin
            expect_d = {stream.data_in, expect_q[7:0]};
            state_d  = CKSUM_LO;
          end else begin
            state_d = CKSUM_HI;
          end
        end

        CKSUM_LO: begin
          if (xfer_s) begin
            expect_d = {expect_q[15:8], stream.data_in};
            state_d  = CHECK;
          end else begin
            state_d = CKSUM_LO;
          end
        end

        CHECK: begin
          if (sum_q == expect_q) begin
            // Padding bits sit in the low end of the last byte and are dropped.
            bitstream_d = shadow_q[SHADOW_W-1 -: BIT_COUNT];
            state_d     = DONE;
          end else begin
            state_d = ERROR;
          end
        end

        default: begin
          state_d  = IDLE;
          shadow_d = {SHADOW_W{1'b0}};
          sum_d    = 16'h0000;
          expect_d = 16'h0000;
          count_d  = 11'd0;
        end
      endcase
    end

    // Status outputs are decoded from the next state so that, once
    // registered, they line up exactly with state_q.
    ready_d = (state_d == LOAD) || (state_d == CKSUM_HI) || (state_d == CKSUM_LO);
    busy_d  = ready_d || (state_d == CHECK);
    done_d  = (state_d == DONE);
    error_d = (state_d == ERROR);
  end

  // State, datapath and output registers with asynchronous reset.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= IDLE;
      shadow_q    <= {SHADOW_W{1'b0}};
      sum_q       <= 16'h0000;
      expect_q    <= 16'h0000;
      count_q     <= 11'd0;
      bitstream_q <= {BIT_COUNT{1'b0}};
      ready_q     <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      error_q     <= 1'b0;
    end else begin
      state_q     <= state_d;
      shadow_q    <= shadow_d;
      sum_q       <= sum_d;
      expect_q    <= expect_d;
      count_q     <= count_d;
      bitstream_q <= bitstream_d;
      ready_q     <= ready_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      error_q     <= error_d;
    end
  end

  assign stream.data_ready = ready_q;
  assign bitstream         = bitstream_q;
  assign busy              = busy_q;
  assign config_done       = done_q;
  assign config_error      = error_q;
  assign byte_count        = count_q;

endmodule : max7000_config_loader
